// File: rtl/adpcm_encoder.sv
// adpcm_encoder: IMA ADPCM encoder, one 16-bit sample in, one 4-bit code out, 7 cycles minimum per sample.
// Define ADPCM_INIT_EN to add the init_valid/init_sample/init_index predictor preload port set.
`timescale 1ns/1ps
module adpcm_encoder (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] sample_in,
   input  logic               sample_valid,
   output logic               sample_ready,
   output logic [3:0]         code_out,
   output logic               code_valid,
   input  logic               code_ready,
`ifdef ADPCM_INIT_EN
   input  logic               init_valid,
   input  logic signed [15:0] init_sample,
   input  logic [6:0]         init_index,
`endif
   output logic signed [15:0] pred_sample_out,
   output logic [6:0]         index_out
);

   typedef enum logic [2:0] {S_IDLE, S_DIFF, S_Q2, S_Q1, S_Q0, S_UPD, S_OUT} state_t;

   localparam logic [15:0] STEP_TBL [89] = '{
      16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
      16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
      16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
      16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
      16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
      16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
      16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
      16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
      16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
      16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
      16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
      16'd32767
   };

   // Index delta is a function of the magnitude bits only; returned as 9-bit two's complement.
   function automatic logic [8:0] idx_delta(input logic [2:0] mag);
      case (mag)
         3'd4:    idx_delta = 9'd2;
         3'd5:    idx_delta = 9'd4;
         3'd6:    idx_delta = 9'd6;
         3'd7:    idx_delta = 9'd8;
         default: idx_delta = 9'h1FF;
      endcase
   endfunction

   state_t             state_q, state_d;
   logic signed [15:0] sample_q, sample_d;
   logic signed [15:0] pred_q, pred_d;
   logic [6:0]         index_q, index_d;
   logic [3:0]         code_q, code_d;
   logic               sign_q, sign_d;
   logic [15:0]        mag_q, mag_d;
   logic [15:0]        step_q, step_d;
   logic [16:0]        vp_q, vp_d;
   logic [2:0]         bits_q, bits_d;
   logic [16:0]        diff;
   logic signed [17:0] p_wide;
   logic [8:0]         i_wide;

   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      pred_d   = pred_q;
      index_d  = index_q;
      code_d   = code_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      step_d   = step_q;
      vp_d     = vp_q;
      bits_d   = bits_q;
      diff     = '0;
      p_wide   = '0;
      i_wide   = '0;
      case (state_q)
         S_IDLE: begin
`ifdef ADPCM_INIT_EN
            if (init_valid) begin
               pred_d  = init_sample;
               index_d = (init_index > 7'd88) ? 7'd88 : init_index;
            end
`endif
            if (sample_valid) begin
               sample_d = sample_in;
               state_d  = S_DIFF;
            end
         end
         S_DIFF: begin
            diff    = {sample_q[15], sample_q} - {pred_q[15], pred_q};
            sign_d  = diff[16];
            mag_d   = diff[16] ? (~diff[15:0] + 16'd1) : diff[15:0];
            step_d  = STEP_TBL[index_q];
            vp_d    = 17'(STEP_TBL[index_q] >> 3);
            bits_d  = 3'b000;
            state_d = S_Q2;
         end
         S_Q2, S_Q1: begin
            if (mag_q >= step_q) begin
               bits_d[(state_q == S_Q2) ? 2 : 1] = 1'b1;
               mag_d = mag_q - step_q;
               vp_d  = vp_q + {1'b0, step_q};
            end
            step_d  = step_q >> 1;
            state_d = (state_q == S_Q2) ? S_Q1 : S_Q0;
         end
         S_Q0: begin
            if (mag_q >= step_q) begin
               bits_d[0] = 1'b1;
               vp_d      = vp_q + {1'b0, step_q};
            end
            state_d = S_UPD;
         end
         S_UPD: begin
            p_wide = sign_q ? ($signed({{2{pred_q[15]}}, pred_q}) - $signed({1'b0, vp_q}))
                            : ($signed({{2{pred_q[15]}}, pred_q}) + $signed({1'b0, vp_q}));
            if (p_wide > 18'sd32767)       pred_d = 16'sd32767;
            else if (p_wide < -18'sd32767) pred_d = -16'sd32767;
            else                           pred_d = p_wide[15:0];
            i_wide = {2'b00, index_q} + idx_delta(bits_q);
            if (i_wide[8])             index_d = 7'd0;
            else if (i_wide > 9'd88)   index_d = 7'd88;
            else                       index_d = i_wide[6:0];
            code_d  = {sign_q, bits_q};
            state_d = S_OUT;
         end
         S_OUT: begin
            if (code_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sample_q <= '0;
         pred_q   <= '0;
         index_q  <= '0;
         code_q   <= '0;
         sign_q   <= 1'b0;
         mag_q    <= '0;
         step_q   <= '0;
         vp_q     <= '0;
         bits_q   <= '0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         pred_q   <= pred_d;
         index_q  <= index_d;
         code_q   <= code_d;
         sign_q   <= sign_d;
         mag_q    <= mag_d;
         step_q   <= step_d;
         vp_q     <= vp_d;
         bits_q   <= bits_d;
      end
   end

   // Ready is held low for the whole reset cycle, not just after the first reset edge.
   assign sample_ready    = (state_q == S_IDLE) && !rst;
   assign code_valid      = (state_q == S_OUT);
   assign code_out        = code_q;
   assign pred_sample_out = pred_q;
   assign index_out       = index_q;

endmodule

// File: tb/tb_adpcm_encoder.sv
// tb_adpcm_encoder: self-checking bench for adpcm_encoder with an integer IMA encoder/decoder model.
// Init-port scenarios are included when ADPCM_INIT_EN is defined.
`timescale 1ns/1ps
module tb_adpcm_encoder;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] sample_in;
   logic               sample_valid;
   logic               sample_ready;
   logic [3:0]         code_out;
   logic               code_valid;
   logic               code_ready;
   logic signed [15:0] pred_sample_out;
   logic [6:0]         index_out;
`ifdef ADPCM_INIT_EN
   logic               init_valid;
   logic signed [15:0] init_sample;
   logic [6:0]         init_index;
`endif

   adpcm_encoder dut (
      .clk             (clk),
      .rst             (rst),
      .sample_in       (sample_in),
      .sample_valid    (sample_valid),
      .sample_ready    (sample_ready),
      .code_out        (code_out),
      .code_valid      (code_valid),
      .code_ready      (code_ready),
`ifdef ADPCM_INIT_EN
      .init_valid      (init_valid),
      .init_sample     (init_sample),
      .init_index      (init_index),
`endif
      .pred_sample_out (pred_sample_out),
      .index_out       (index_out)
   );

   always #5 clk = ~clk;

   int STEP [89] = '{
      7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
      73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371, 408,
      449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
      2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630,
      9493, 10442, 11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
   };
   int IDX [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

   typedef struct { int code; int pred; int idx; } exp_t;
   exp_t exp_q [$];

   int n_cmp = 0;
   int n_err = 0;
   int m_pred = 0, m_idx = 0;
   int d_pred = 0, d_idx = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // Encoder model: successive approximation of |diff| against step, step/2, step/4.
   task automatic model_encode(input int s, output int code);
      int step, diff, mag, vp;
      step = STEP[m_idx];
      diff = s - m_pred;
      mag  = (diff < 0) ? -diff : diff;
      code = (diff < 0) ? 8 : 0;
      vp   = step / 8;
      for (int b = 2; b >= 0; b--) begin
         if (mag >= step) begin
            code = code | (1 << b);
            mag  = mag - step;
            vp   = vp + step;
         end
         step = step / 2;
      end
      m_pred = clamp(((code & 8) != 0) ? m_pred - vp : m_pred + vp, -32767, 32767);
      m_idx  = clamp(m_idx + IDX[code & 7], 0, 88);
   endtask

   // Independent decoder, reconstructs the predictor from the code stream alone.
   task automatic decode(input int code);
      int step, vp;
      step = STEP[d_idx];
      vp = step / 8;
      if ((code & 4) != 0) vp += step;
      if ((code & 2) != 0) vp += step / 2;
      if ((code & 1) != 0) vp += step / 4;
      d_pred = clamp(((code & 8) != 0) ? d_pred - vp : d_pred + vp, -32767, 32767);
      d_idx  = clamp(d_idx + IDX[code & 7], 0, 88);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         d_pred = 0;
         d_idx  = 0;
      end else begin
`ifdef ADPCM_INIT_EN
         if (init_valid && sample_ready) begin
            d_pred = int'(init_sample);
            d_idx  = (int'(init_index) > 88) ? 88 : int'(init_index);
         end
`endif
         if (code_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_code_valid", 1, 0);
            end else begin
               check("code", int'(code_out), exp_q[0].code);
               check("pred", int'(pred_sample_out), exp_q[0].pred);
               check("index", int'(index_out), exp_q[0].idx);
               check("ready_low_in_out", int'(sample_ready), 0);
               if (code_ready) begin
                  decode(int'(code_out));
                  check("decoder_pred", int'(pred_sample_out), d_pred);
                  check("decoder_index", int'(index_out), d_idx);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      m_pred = 0;
      m_idx  = 0;
      exp_q.delete();
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic send(input int s, input int stall, input int gap);
      int n, lat, code;
      exp_t e;
      repeat (gap) tick();
      n = 0;
      while (!sample_ready && n < 40) begin
         tick();
         n++;
      end
      if (!sample_ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      sample_in    = 16'(s);
      sample_valid = 1'b1;
      code_ready   = (stall == 0);
      model_encode(s, code);
      e.code = code; e.pred = m_pred; e.idx = m_idx;
      exp_q.push_back(e);
      tick();
      lat = 0;
      while (!code_valid && lat < 20) begin
         sample_valid = 1'($urandom);
         sample_in    = 16'($urandom);
         tick();
         lat++;
      end
      sample_valid = 1'b0;
      check("latency", lat, 5);
      for (int i = 0; i < stall; i++) begin
         check("stall_ready_low", int'(sample_ready), 0);
         tick();
      end
      code_ready = 1'b1;
      tick();
      check("valid_drop", int'(code_valid), 0);
      check("ready_rise", int'(sample_ready), 1);
      code_ready = 1'($urandom);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [15:0] r;
      int s;
      rst = 1'b1; sample_in = '0; sample_valid = 1'b0; code_ready = 1'b0;
`ifdef ADPCM_INIT_EN
      init_valid = 1'b0; init_sample = '0; init_index = '0;
`endif
      tick();
      check("rst_sample_ready", int'(sample_ready), 0);
      check("rst_code_valid", int'(code_valid), 0);
      check("rst_code_out", int'(code_out), 0);
      check("rst_pred", int'(pred_sample_out), 0);
      check("rst_index", int'(index_out), 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", int'(sample_ready), 1);

      send(100, 0, 0);
      check("lit_pos_code", int'(code_out), 7);
      check("lit_pos_pred", int'(pred_sample_out), 11);
      check("lit_pos_index", int'(index_out), 8);

      do_reset(2);
      send(-100, 0, 0);
      check("lit_neg_code", int'(code_out), 15);
      check("lit_neg_pred", int'(pred_sample_out), -11);
      check("lit_neg_index", int'(index_out), 8);

      do_reset(2);
      send(0, 0, 0);
      check("lit_zero_code", int'(code_out), 0);
      check("lit_zero_pred", int'(pred_sample_out), 0);
      check("lit_zero_index", int'(index_out), 0);

      do_reset(2);
      for (int i = 0; i < 200; i++) send(32767, 0, 0);
      check("lit_full_pred", int'(pred_sample_out), 32767);
      check("lit_full_index", int'(index_out), 0);

      do_reset(2);
      for (int i = 0; i < 60; i++) send((i % 2 == 0) ? 32767 : -32768, 0, 0);
      check("lit_alt_index_sat", int'(index_out), 88);

      do_reset(2);
      send(300, 0, 0);
      send(-2000, 10, 0);

      send(500, 0, 0);
      sample_in = 16'sd1234;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      m_pred = 0;
      m_idx  = 0;
      tick();
      check("abort_code_valid", int'(code_valid), 0);
      check("abort_pred", int'(pred_sample_out), 0);
      check("abort_index", int'(index_out), 0);
      rst = 1'b0;
      #1;
      check("abort_ready", int'(sample_ready), 1);
      send(100, 0, 0);
      check("lit_abort_code", int'(code_out), 7);
      check("lit_abort_pred", int'(pred_sample_out), 11);
      check("lit_abort_index", int'(index_out), 8);

      do_reset(2);
      for (int k = 0; k < 24; k++) begin
         s = $rtoi(20000.0 * $sin(6.283185307 * real'(k) / 8.0));
         send(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      for (int k = 0; k < 60; k++) begin
         r = 16'($urandom);
         send(int'(r), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

`ifdef ADPCM_INIT_EN
      do_reset(2);
      init_sample = 16'sd1000;
      init_index  = 7'd20;
      init_valid  = 1'b1;
      tick();
      init_valid = 1'b0;
      m_pred = 1000;
      m_idx  = 20;
      send(1000, 0, 0);
      check("lit_init_code", int'(code_out), 0);
      check("lit_init_index", int'(index_out), 19);
`endif

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
